// File: rtl/padded_ifm_reader.sv
// Streams the 3x3 windows of a padded square feature map out of a row buffer.
// Define PADDED_IFM_READER_STRIDE2_EN to honour the stride2 input.
module padded_ifm_reader #(
    parameter int PE     = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [10:0]       IFM_C,
    input  logic [10:0]       IFM_W,
    input  logic              padding,
    input  logic              stride2,
    input  logic [31:0]       base_addr,
    input  logic [11:0]       rows_written,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [127:0]      rd_data,
    output logic [127:0]      data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              last_word,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic              load, issue, last_rd, last_tag, row_ok;
    logic              s2_in, s2_cur;
    logic [10:0]       cw_in;
    logic [11:0]       wp_in, lim_in, row_inc;
    logic              degen_in;
    logic [ADDR_W-1:0] row_step_in, col_step_in, row_jump_in, base_in;

    logic [11:0]       lim_q, oy_q, ox_q, win_row_q, cur_row_q;
    logic [10:0]       cw_last_q, cw_q;
    logic [1:0]        ky_q, kx_q;
    logic [ADDR_W-1:0] row_step_q, col_step_q, row_jump_q;
    logic [ADDR_W-1:0] rowo_q, orig_q, kline_q, addr_q;

    logic [128:0]      mem_q [2];
    logic              wr_q, rd_q, infl_q, infl_last_q, push, pop;
    logic [1:0]        cnt_q;
    logic [2:0]        credit;

    assign load = (state_q == IDLE) && start;

`ifdef PADDED_IFM_READER_STRIDE2_EN
    logic s2_q;
    assign s2_in  = stride2;
    assign s2_cur = s2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2_q <= 1'b0;
        else if (load)
            s2_q <= stride2;
    end
`else
    logic unused_stride2;
    assign unused_stride2 = stride2;
    assign s2_in  = 1'b0;
    assign s2_cur = 1'b0;
`endif

    // Per-map constants; the only multiply happens once at start.
    assign cw_in       = IFM_C / 11'(PE);
    assign wp_in       = {1'b0, IFM_W} + {10'd0, padding, 1'b0};
    assign degen_in    = (cw_in == 11'd0) || (wp_in < 12'd3);
    assign lim_in      = s2_in ? ((wp_in - 12'd3) >> 1) : (wp_in - 12'd3);
    assign row_step_in = ADDR_W'(23'(wp_in) * 23'(cw_in));
    assign col_step_in = s2_in ? ADDR_W'({cw_in, 1'b0}) : ADDR_W'(cw_in);
    assign row_jump_in = s2_in ? (row_step_in << 1) : row_step_in;
    assign base_in     = ADDR_W'(base_addr >> 4);
    assign row_inc     = s2_cur ? 12'd2 : 12'd1;

    assign valid_out = (cnt_q != 2'd0);
    assign pop       = valid_out && ready_in;
    assign push      = infl_q;
    assign credit    = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
    assign row_ok    = cur_row_q < rows_written;
    assign issue     = (state_q == ISSUE) && row_ok && (credit < 3'd2);
    assign last_tag  = (ky_q == 2'd2) && (kx_q == 2'd2) && (cw_q == cw_last_q);
    assign last_rd   = last_tag && (ox_q == lim_q) && (oy_q == lim_q);

    assign rd_en     = issue;
    assign rd_addr   = addr_q;
    assign data_out  = valid_out ? mem_q[rd_q][127:0] : '0;
    assign last_word = valid_out && mem_q[rd_q][128];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = degen_in ? DONE : ISSUE;
            ISSUE:   if (issue && last_rd) state_d = DRAIN;
            DRAIN:   if (cnt_q == 2'd0 && !infl_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window walk: oy, ox, ky, kx, cw with incremental address update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_q      <= '0;
            cw_last_q  <= '0;
            row_step_q <= '0;
            col_step_q <= '0;
            row_jump_q <= '0;
            oy_q       <= '0;
            ox_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            cw_q       <= '0;
            win_row_q  <= '0;
            cur_row_q  <= '0;
            rowo_q     <= '0;
            orig_q     <= '0;
            kline_q    <= '0;
            addr_q     <= '0;
        end else if (load) begin
            lim_q      <= lim_in;
            cw_last_q  <= cw_in - 11'd1;
            row_step_q <= row_step_in;
            col_step_q <= col_step_in;
            row_jump_q <= row_jump_in;
            oy_q       <= '0;
            ox_q       <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            cw_q       <= '0;
            win_row_q  <= '0;
            cur_row_q  <= '0;
            rowo_q     <= base_in;
            orig_q     <= base_in;
            kline_q    <= base_in;
            addr_q     <= base_in;
        end else if (issue) begin
            if (cw_q != cw_last_q) begin
                cw_q   <= cw_q + 11'd1;
                addr_q <= addr_q + ADDR_W'(1);
            end else begin
                cw_q <= '0;
                if (kx_q != 2'd2) begin
                    kx_q   <= kx_q + 2'd1;
                    addr_q <= addr_q + ADDR_W'(1);
                end else begin
                    kx_q <= '0;
                    if (ky_q != 2'd2) begin
                        ky_q      <= ky_q + 2'd1;
                        cur_row_q <= cur_row_q + 12'd1;
                        kline_q   <= kline_q + row_step_q;
                        addr_q    <= kline_q + row_step_q;
                    end else begin
                        ky_q <= '0;
                        if (ox_q != lim_q) begin
                            ox_q      <= ox_q + 12'd1;
                            cur_row_q <= win_row_q;
                            orig_q    <= orig_q + col_step_q;
                            kline_q   <= orig_q + col_step_q;
                            addr_q    <= orig_q + col_step_q;
                        end else if (oy_q != lim_q) begin
                            ox_q      <= '0;
                            oy_q      <= oy_q + 12'd1;
                            win_row_q <= win_row_q + row_inc;
                            cur_row_q <= win_row_q + row_inc;
                            rowo_q    <= rowo_q + row_jump_q;
                            orig_q    <= rowo_q + row_jump_q;
                            kline_q   <= rowo_q + row_jump_q;
                            addr_q    <= rowo_q + row_jump_q;
                        end
                    end
                end
            end
        end
    end

    // Read return tracking and the two-entry output FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            infl_q      <= issue;
            infl_last_q <= issue && last_tag;
            if (push)
                wr_q <= ~wr_q;
            if (pop)
                rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= {infl_last_q, rd_data};
    end

endmodule

// File: tb/tb_padded_ifm_reader.sv
// Self-checking bench for padded_ifm_reader: table vectors, random maps,
// and hand sequences for reset abort, latency and degenerate shapes.
module tb_padded_ifm_reader;

    localparam int PE = 16;
    localparam int AW = 32;
`ifdef PADDED_IFM_READER_STRIDE2_EN
    localparam bit STRIDE_ON = 1'b1;
`else
    localparam bit STRIDE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [10:0]   IFM_C = '0;
    logic [10:0]   IFM_W = '0;
    logic          padding = 1'b0;
    logic          stride2 = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [11:0]   rows_written = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [127:0]  rd_data = '0;
    logic [127:0]  data_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic          last_word;
    logic          busy;
    logic          done;

    padded_ifm_reader #(.PE(PE), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .IFM_C(IFM_C), .IFM_W(IFM_W), .padding(padding), .stride2(stride2),
        .base_addr(base_addr), .rows_written(rows_written),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
        .last_word(last_word), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        int          w;
        int          p;
        int          s2;
        int          rdy;
        int          rwm;
        int          rw;
        logic [31:0] base;
        int          words;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int tcyc = 0;
    int n_reads, n_words, n_done, first_rd, first_val;
    logic [31:0] exp_addr[$];
    int          exp_row[$];
    bit          exp_last[$];
    logic [31:0] got_addr[$];
    logic [31:0] addr_max;
    bit          stall_q = 1'b0;
    logic [127:0] stall_data;
    logic        stall_last;

    function automatic logic [127:0] word_of(input logic [31:0] a);
        return {a, a ^ 32'hA5A5_5A5A, ~a, a * 32'h9E37_79B9};
    endfunction

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: enumerate every window word straight from the map geometry.
    task automatic build_model(input vec_t v);
        int cwn, wp, s, oh, row;
        exp_addr.delete();
        exp_row.delete();
        exp_last.delete();
        cwn = v.c / PE;
        wp  = v.w + 2 * v.p;
        s   = (STRIDE_ON && v.s2 != 0) ? 2 : 1;
        addr_max = v.base / 16 + wp * wp * cwn - 1;
        if (cwn > 0 && wp >= 3) begin
            oh = (wp - 3) / s + 1;
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < oh; ox++)
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            for (int c = 0; c < cwn; c++) begin
                                row = oy * s + ky;
                                exp_addr.push_back(v.base / 16 +
                                    (row * wp + ox * s + kx) * cwn + c);
                                exp_row.push_back(row);
                                exp_last.push_back(ky == 2 && kx == 2 && c == cwn - 1);
                            end
        end
    endtask

    always @(posedge clk) begin
        tcyc++;
        if (rd_en)
            rd_data <= word_of(rd_addr);
        else
            rd_data <= {4{$urandom()}};
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (rd_en) begin
                if (n_reads < exp_addr.size()) begin
                    check("rd_addr", rd_addr, exp_addr[n_reads]);
                    check("row_ready", exp_row[n_reads] < rows_written, 1'b1);
                end else begin
                    check("extra_read", n_reads + 1, exp_addr.size());
                end
                check("addr_bound", rd_addr <= addr_max, 1'b1);
                got_addr.push_back(rd_addr);
                if (first_rd < 0) first_rd = tcyc;
                n_reads++;
            end
            if (valid_out && first_val < 0) first_val = tcyc;
            if (stall_q) begin
                check("stall_valid", valid_out, 1'b1);
                check("stall_data", data_out, stall_data);
                check("stall_last", last_word, stall_last);
            end
            if (valid_out && ready_in) begin
                if (n_words < exp_addr.size()) begin
                    check("data_out", data_out, word_of(exp_addr[n_words]));
                    check("last_word", last_word, exp_last[n_words]);
                end else begin
                    check("extra_word", n_words + 1, exp_addr.size());
                end
                n_words++;
            end
            stall_q    = valid_out && !ready_in;
            stall_data = data_out;
            stall_last = last_word;
            if (done) n_done++;
        end
    end

    task automatic drive(input vec_t v, input int cyc, input int wp);
        case (v.rdy)
            0:       ready_in = 1'b1;
            1:       ready_in = (cyc % 2 == 0);
            default: ready_in = ($urandom_range(0, 3) != 0);
        endcase
        case (v.rwm)
            0:       rows_written = 12'(v.rw);
            1:       rows_written = (cyc < 20) ? 12'd2 : 12'(v.rw);
            default: rows_written = 12'((1 + cyc / 7 < wp) ? 1 + cyc / 7 : wp);
        endcase
    endtask

    task automatic check_zero_outputs();
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_data_out", data_out, 0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_last_word", last_word, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int abort_at);
        int cyc, wp;
        bit fin;
        build_model(v);
        n_reads = 0;
        n_words = 0;
        n_done = 0;
        first_rd = -1;
        first_val = -1;
        got_addr.delete();
        wp = v.w + 2 * v.p;
        @(posedge clk); #1;
        IFM_C = 11'(v.c);
        IFM_W = 11'(v.w);
        padding = v.p[0];
        stride2 = v.s2[0];
        base_addr = v.base;
        start = 1'b1;
        cyc = 0;
        drive(v, cyc, wp);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        drive(v, cyc, wp);
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        if (v.words == 0) check("early_done", done, 1'b1);
        fin = 1'b0;
        while (!fin && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            drive(v, cyc, wp);
            if (n_done > 0) fin = 1'b1;
            if (abort_at > 0 && n_words >= abort_at) break;
        end
        if (abort_at > 0) begin
            check("done_before_abort", n_done, 0);
            rst = 1'b1;
            @(negedge clk);
            check_zero_outputs();
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            checks++;
            if (!fin) begin
                errors++;
                $display("FAIL timeout: %0d words after %0d cycles, required %0d",
                         n_words, cyc, v.words);
            end
            check("word_count", n_words, v.words);
            check("model_count", n_words, exp_addr.size());
            check("read_count", n_reads, exp_addr.size());
            check("done_pulses", n_done, 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t rv;
        int offs[9];
        int wp, s, oh;
        tbl[0] = '{16, 4, 1, 0, 0, 0, 6, 32'h0000_1000, 144};
        tbl[1] = '{16, 4, 1, 0, 1, 0, 6, 32'h0000_1000, 144};
        tbl[2] = '{16, 4, 1, 0, 0, 1, 6, 32'h0000_2008, 144};
        tbl[3] = '{32, 5, 1, 1, 0, 0, 7, 32'h0000_4000, STRIDE_ON ? 162 : 450};
        tbl[4] = '{0, 4, 1, 0, 0, 0, 6, 32'h0000_0100, 0};
        tbl[5] = '{16, 1, 0, 0, 0, 0, 1, 32'h0000_0100, 0};
        tbl[6] = '{48, 3, 0, 0, 1, 0, 3, 32'h0000_0300, 27};
        tbl[7] = '{16, 1, 1, 1, 2, 0, 3, 32'h0000_0000, 9};
        offs = '{0, 1, 2, 6, 7, 8, 12, 13, 14};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i], 0);
            if (i == 0) begin
                for (int k = 0; k < 9; k++)
                    check("first_window_addr", got_addr[k], 32'h100 + offs[k]);
                check("rd_to_valid_latency", first_val - first_rd, 2);
            end
            if (i == 3) begin
                check("stride_addr0", got_addr[0], 32'h400);
                check("stride_addr1", got_addr[1], 32'h401);
                check("stride_win1", got_addr[18], STRIDE_ON ? 32'h404 : 32'h402);
            end
        end

        run_vec(tbl[0], 50);
        run_vec(tbl[0], 0);
        check("fresh_after_abort", got_addr[0], 32'h100);

        for (int i = 0; i < 6; i++) begin
            rv.c = PE * $urandom_range(1, 3);
            rv.w = $urandom_range(1, 6);
            rv.p = $urandom_range(0, 1);
            rv.s2 = $urandom_range(0, 1);
            rv.rdy = 2;
            rv.rwm = 2;
            rv.rw = 0;
            rv.base = $urandom_range(0, 32'h0FFF_FFFF);
            wp = rv.w + 2 * rv.p;
            s = (STRIDE_ON && rv.s2 != 0) ? 2 : 1;
            oh = (wp >= 3) ? (wp - 3) / s + 1 : 0;
            rv.words = oh * oh * 9 * (rv.c / PE);
            run_vec(rv, 0);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
